// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter that shares one FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_full,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] winner;
    logic [IW-1:0] next_ptr;
    logic [BW-1:0] beat_cnt;
    logic          release_beat;

    // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        winner = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) winner = IW'((int'(rr_ptr) + k) % NUM_REQ);
    end

    assign fifo_wr_en   = (state == BURST) && req_valid[grant_id] && !fifo_full;
    assign req_ready    = (state == BURST && !fifo_full) ? NUM_REQ'(1) << grant_id : '0;
    assign fifo_wr_data = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
    assign release_beat = req_last[grant_id] || beat_cnt == BW'(MAX_BURST - 1);
    assign next_ptr     = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
        end else if (state == IDLE) begin
            if (|req_valid) begin
                state    <= BURST;
                busy     <= 1'b1;
                grant_id <= winner;
                beat_cnt <= '0;
            end
        end else if (fifo_wr_en) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (release_beat) begin
                state  <= IDLE;
                busy   <= 1'b0;
                rr_ptr <= next_ptr;
            end
        end
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares a single `fifo` instance among `NUM_REQ` producers. Each producer presents a valid/ready/last burst stream. The arbiter grants one producer at a time, for up to `MAX_BURST` beats, and drives the FIFO's `wr_en`/`wr_data` while honouring `full`. It sits directly in front of the `fifo` write port; the read side is untouched.

## Interface
- `DATA_WIDTH`, 32, width of each data beat; matches the FIFO `DATA_WIDTH`.
- `NUM_REQ`, 4, number of producers; must be 2..16.
- `MAX_BURST`, 4, maximum beats per grant before a forced release; must be ≥1.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  NUM_REQ  per-producer beat valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH  per-producer data; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last`  in  NUM_REQ  marks the final beat of the producer's burst.
- `req_ready`  out  NUM_REQ  beat-accepted qualifier; at most one bit is set at any time.
- `fifo_wr_en`  out  1  to FIFO `wr_en`.
- `fifo_wr_data`  out  DATA_WIDTH  to FIFO `wr_data`.
- `fifo_full`  in  1  from FIFO `full`.
- `grant_id`  out  $clog2(NUM_REQ)  current or most recent owner.
- `busy`  out  1  high while a grant is active.

## Operation
- Two-state FSM: IDLE and BURST.
- **IDLE:**
  - `req_ready` = 0 and `fifo_wr_en` = 0.
  - If any `req_valid` is set, select the first set bit scanning upward from `rr_ptr`, wrapping modulo NUM_REQ.
  - On the next edge: register the winner as `grant_id`, clear `beat_cnt`, go to BURST.
- **BURST** (owner = `grant_id`):
  - `req_ready[owner]` = !`fifo_full`; all other ready bits are 0.
  - `fifo_wr_en` = `req_valid[owner]` & !`fifo_full`. This is combinational, so the beat is written on the same edge it is accepted.
  - `fifo_wr_data` = `req_data[owner]`, combinational mux.
  - Accepted beat = `fifo_wr_en` high at a rising edge. Each accepted beat increments `beat_cnt`.
  - Release occurs on an accepted beat that either has `req_last[owner]` = 1 or brings `beat_cnt` to MAX_BURST. On release: `rr_ptr` ← (owner+1) mod NUM_REQ, go to IDLE.
  - If the owner deasserts `req_valid` mid-burst, the grant is held. There is no timeout, and no write occurs while valid is low.
- **`fifo_full`:** while full is high, no write is issued and `req_ready` is 0. `beat_cnt` and state are unchanged; the burst resumes when full drops.
- **Widths:** `beat_cnt` is $clog2(MAX_BURST+1) bits. `rr_ptr` and `grant_id` are $clog2(NUM_REQ) bits; the wrap is explicit for non-power-of-two NUM_REQ.
- **Reset** (asynchronous, takes effect mid-operation):
  - State → IDLE; `rr_ptr`, `grant_id`, `beat_cnt` → 0; `busy` → 0.
  - `req_ready` and `fifo_wr_en` → 0 immediately.
  - Beats already written remain the FIFO's concern. A partial burst is abandoned, and producers must restart it.

## Timing
- Grant latency: 1 cycle from the first `req_valid` seen in IDLE to `busy` = 1.
- Every burst is followed by exactly one IDLE bubble cycle. Peak throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- Within BURST, ready/wr_en follow valid and full combinationally, with zero-cycle latency to the FIFO.
- `busy` and `grant_id` are registered. `grant_id` keeps its last value in IDLE.
- Fairness: a continuously requesting producer is granted within NUM_REQ−1 intervening bursts.
- `req_ready` is never high for a non-owner, and never high while `fifo_full` = 1.
- No combinational path exists from `req_valid` to `req_ready`.

## Test plan
1. Reset, then producer 2 sends 0xA1, 0xA2 (last on 0xA2).
   - Response: `busy` rises 1 cycle after valid, `grant_id` = 2, FIFO receives 0xA1 then 0xA2 on consecutive edges.
   - Then `busy` drops and the read-drain returns 0xA1, 0xA2.
2. All 4 producers hold single-beat bursts (last = 1) continuously.
   - Response: `grant_id` sequence 0,1,2,3,0. One write per 2 cycles; no producer is written twice before all have been served.
3. Producer 1 streams 6 beats with no last, MAX_BURST = 4, and producer 3 is also valid.
   - Response: 4 beats from producer 1 are written, then producer 3 is granted, then producer 1 finishes its remaining 2 beats.
4. Force `fifo_full` = 1 for 3 cycles after the 2nd beat of a 4-beat burst.
   - Response: `req_ready` = 0 and `fifo_wr_en` = 0 during those cycles, `beat_cnt` stays at 2.
   - Beats 3 and 4 are written after full drops; the FIFO contents are in order with none lost or duplicated.
5. Owner drops `req_valid` for 2 cycles mid-burst while another producer is valid.
   - Response: the grant is held, no `fifo_wr_en`, and the burst completes when valid returns.
6. Assert `reset_n` low mid-burst, between clock edges.
   - Response: `fifo_wr_en`, `req_ready` and `busy` go to 0 immediately.
   - After release, the first grant with all producers valid goes to producer 0.
